// File: rtl/enc_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin select scheduler and the
// one-hot encoder it feeds.
package enc_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    localparam int ENC_NREQ = 15;
    localparam int ENC_IDXW = 4;

endpackage

// File: rtl/enc_rr_scheduler_if.sv
// Requester/scheduler bundle: level requests and release in, registered
// grant pair (encoder in_valid/in) and timeout pulse out.
interface enc_rr_scheduler_if
    import enc_sched_pkg::*;
#(
    parameter int NREQ = ENC_NREQ,
    parameter int IDXW = ENC_IDXW
);
    logic [NREQ-1:0] req;
    logic            rel;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic            timeout;

    modport master (
        output req, rel,
        input  grant_valid, grant_idx, timeout
    );

    modport slave (
        input  req, rel,
        output grant_valid, grant_idx, timeout
    );
endinterface

// File: rtl/enc_rr_scheduler_rr_pick.sv
// Combinational round-robin search: first set request strictly after ptr,
// wrapping from NREQ-1 to 0.
module rr_pick #(
    parameter int NREQ = 15,
    parameter int IDXW = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    assign found = |req;

    // Walk the search distance downward so the nearest hit is written last.
    always_comb begin
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ])
                idx = IDXW'((int'(ptr) + k) % NREQ);
        end
    end

endmodule

// File: rtl/enc_rr_scheduler.sv
// Round-robin scheduler holding one grant per tenure for the shared select
// encoder. Optional tenure limit under `ENC_SCHED_TIMEOUT_EN`.
module enc_rr_scheduler
    import enc_sched_pkg::*;
#(
    parameter int NREQ     = ENC_NREQ,
    parameter int IDXW     = ENC_IDXW,
    parameter int HOLD_MAX = 64
) (
    input  logic                clk,
    input  logic                rst,
    enc_rr_scheduler_if.slave   bus
);

    if (HOLD_MAX < 2 || (2 ** IDXW) <= NREQ) begin : g_bad_cfg
        $error("enc_rr_scheduler: illegal HOLD_MAX/IDXW/NREQ combination");
    end

    sched_state_t    state, state_nxt;
    logic [IDXW-1:0] last, last_nxt;
    logic [IDXW-1:0] idx_q, idx_nxt;
    logic            gv_q, gv_nxt;
    logic            found;
    logic [IDXW-1:0] pick_idx;
    logic            owner_gone;
    logic            hit;

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req   (bus.req),
        .ptr   (last),
        .found (found),
        .idx   (pick_idx)
    );

    assign owner_gone = ~bus.req[idx_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= IDXW'(NREQ - 1);
            idx_q <= '0;
            gv_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            idx_q <= idx_nxt;
            gv_q  <= gv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        idx_nxt   = idx_q;
        gv_nxt    = gv_q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    idx_nxt   = pick_idx;
                    gv_nxt    = 1'b1;
                end
            end
            BUSY: begin
                if (bus.rel || owner_gone || hit) begin
                    state_nxt = IDLE;
                    last_nxt  = idx_q;
                    gv_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gv_nxt    = 1'b0;
            end
        endcase
    end

    assign bus.grant_valid = gv_q;
    assign bus.grant_idx   = idx_q;

`ifdef ENC_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX);

    logic [CW-1:0] hold_cnt;
    logic          start;
    logic          to_q;

    assign start = (state == IDLE) && found;
    assign hit   = (state == BUSY) && (hold_cnt == CW'(HOLD_MAX - 1));

    // A release or withdrawal in the same cycle wins; the pulse only marks
    // tenures that nothing else would have ended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            to_q <= hit && !bus.rel && !owner_gone;
            if (start)
                hold_cnt <= '0;
            else if (state == BUSY)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign bus.timeout = to_q;
`else
    assign hit         = 1'b0;
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: doc/enc_rr_scheduler.md
# enc_rr_scheduler

Round-robin scheduler sharing the binary-to-one-hot select encoder among 15 requesters. It arbitrates the request vector and holds the grant until the owner releases it. It drives the encoder's `in_valid`/`in` pair from registered outputs, so the decoded one-hot select is glitch-free and stable for the whole tenure. It sits directly upstream of `enc_bin2onehot` in the select path.

## Interface
- `NREQ`, 15: number of requesters; must equal the encoder's one-hot width.
- `IDXW`, 4: grant index width; `2**IDXW > NREQ`.
- `HOLD_MAX`, 64: maximum tenure in cycles when the timeout feature is compiled in; ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input NREQ: level request per requester; bit i is requester i.
- `rel` input 1: the owner releases the grant; sampled only in BUSY.
- `grant_valid` output 1: a grant is active; connects to the encoder `in_valid`.
- `grant_idx` output IDXW: binary index of the owner; connects to the encoder `in`.
- `timeout` output 1: one-cycle pulse when a tenure is force-ended.

## Operation
- FSM with two states: IDLE and BUSY.
- **IDLE**
  - `grant_valid`=0.
  - If `req` is nonzero, pick the first set bit searching from `last+1` upward with wrap (index NREQ-1 wraps to 0).
  - Register the winner into `grant_idx`, set `grant_valid`=1 and go to BUSY.
  - If `req`=0, stay in IDLE.
- **BUSY**
  - `grant_idx` is frozen.
  - Tenure ends when any of the following holds in a cycle:
    - `rel`=1;
    - `req[grant_idx]`=0, meaning the owner withdrew;
    - a timeout fires.
  - On tenure end: `last`←`grant_idx`, `grant_valid`←0, go to IDLE.
  - Otherwise stay in BUSY.
- Priority pointer `last` resets to NREQ-1, so the first search starts at index 0.
- Requests from non-owners are ignored during BUSY; they are not queued, and remain pending as levels.
- `grant_idx` keeps its last value while `grant_valid`=0. The encoder gates on valid.
- The search only ever returns values in 0..NREQ-1. Index values ≥ NREQ are never produced.
- Reset mid-tenure: asynchronous; drops `grant_valid` immediately, with no release handshake.

## Timing
- Reset values:
  - `grant_valid`=0, `grant_idx`=0, `timeout`=0;
  - state=IDLE, `last`=NREQ-1, hold counter=0.
- Grant latency: a request seen in IDLE at edge N gives `grant_valid`=1 after edge N.
- Release latency: `rel` seen at edge M gives `grant_valid`=0 after edge M.
- Mandatory one-cycle gap: `grant_valid` is low for at least one full cycle between tenures, since arbitration happens only in IDLE. This guarantees the encoder output passes through all-zero between owners.
- Minimum tenure is one cycle; `rel` may already be high in the first BUSY cycle.
- Simultaneous `rel` and owner withdrawal: treated as a single release.
- Simultaneous `rel` and timeout: treated as a release; `timeout` stays 0.

## Configuration
- `ENC_SCHED_TIMEOUT_EN` defined:
  - A hold counter of width `$clog2(HOLD_MAX)` clears on entry to BUSY and increments each BUSY cycle.
  - In the cycle where the counter equals HOLD_MAX-1, the tenure ends and `timeout` pulses high for one cycle, together with `grant_valid` falling.
  - Effect: a grant lasts at most HOLD_MAX cycles.
- `ENC_SCHED_TIMEOUT_EN` undefined:
  - No counter is built, `timeout` is tied 0, and tenure is unbounded.

## Structure
- Shared package `enc_sched_pkg` holds:
  - the state enum `sched_state_t` {IDLE, BUSY};
  - the constants `ENC_NREQ`=15 and `ENC_IDXW`=4, shared with the encoder instance.
- One sub-module: `rr_pick`. It is combinational; it takes a request vector and a pointer and returns `found` plus the binary index of the first set bit after the pointer, with wrap.
- The top level holds the FSM, the `last` pointer, the output registers and the optional counter.

## Test plan
- Reset then `req`=0x0001 → `grant_valid`=1 and `grant_idx`=0 one cycle after sampling; `rel` pulse → `grant_valid`=0 the next cycle.
- `req`=0x7FFF held, `rel` pulsed every BUSY cycle → `grant_idx` sequence 0,1,2,…,14,0, with a one-cycle `grant_valid`-low gap between each.
- `last`=14 and `req`=0x4001 → grant 0. Then `last`=0 and `req`=0x4001 → grant 14 (wrap check).
- Owner 5 granted, then `req[5]` drops with no `rel` → `grant_valid`=0 the next cycle and `last`=5. A `req[7]` arriving meanwhile is granted after the gap.
- With the macro defined, HOLD_MAX=4 and `req`=0x0008 held with no `rel` → `grant_valid` high exactly 4 cycles; `timeout` pulses on the 4th; regrant to 3 after one gap cycle. Without the macro → the grant holds indefinitely and `timeout` stays 0.
- Assert `rst` low while in BUSY → `grant_valid`=0 immediately. After deassertion, `req`=0x0004 → grant 2 (pointer restarted at index 0).
